fir_out_packer: RTL and testbench
=================================

# fir_out_packer

Downstream stage of the FIR filter. Captures each signed `y_n` result on a valid strobe and buffers it in a small FIFO. Each sample leaves on the 8-bit output pins as two self-framing bytes under a valid/ready handshake, with no bubble between back-to-back samples. Output rate is decoupled from the filter rate; samples arriving while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- `Y_N_SIZE`, 11, width of the incoming filter result; legal range 2..14.
- `FIFO_DEPTH`, 4, sample buffer depth; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `y_n`  in  Y_N_SIZE  signed filter result.
- `y_valid`  in  1  `y_n` is a new sample this cycle.
- `out_byte`  out  8  framed output byte.
- `out_valid`  out  1  `out_byte` holds a byte to transfer.
- `out_ready`  in  1  consumer accepts `out_byte` this cycle.
- `overflow`  out  1  sticky flag: at least one sample was dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  samples currently buffered.

## Operation
- **Word format.** `y_n` is sign-extended to 14 bits, `w`.
  - HI byte = {1'b1, w[13:7]}.
  - LO byte = {1'b0, w[6:0]}.
  - Bit 7 marks the first byte of a sample, so the receiver can resynchronise framing.
- **Push.** At a rising edge with `y_valid`=1, the sample is written if `fifo_level` < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise it is dropped and `overflow` is set.
- **`overflow`.** Cleared only by `reset`.
- **FSM states.** IDLE, SEND_HI, SEND_LO.
  - IDLE: `out_valid`=0. If `fifo_level`>0, pop the head into the output word register and go to SEND_HI.
  - SEND_HI: `out_byte`=HI, `out_valid`=1. On `out_ready`=1, go to SEND_LO.
  - SEND_LO: `out_byte`=LO, `out_valid`=1. On `out_ready`=1: if `fifo_level`>0, pop the next sample and go to SEND_HI; otherwise go to IDLE.
- **Handshake.** A transfer occurs at a rising edge where `out_valid` and `out_ready` are both 1. While `out_valid`=1 and no transfer has occurred, `out_byte` is held stable. `out_valid` never drops without a transfer, except on reset.
- **`fifo_level`.** Registered: +1 on push only, −1 on pop only, unchanged on push+pop or neither.

## Timing
- **Reset values.** `out_byte`=0, `out_valid`=0, `overflow`=0, `fifo_level`=0, FSM=IDLE, FIFO pointers=0.
- **Latency.** A sample pushed at edge N into an empty FIFO with the FSM idle gives `out_valid`=1 with its HI byte after edge N+1.
- **Throughput.** With `out_ready` held 1, one sample per 2 cycles. The LO byte of sample k is followed directly by the HI byte of sample k+1.
- **Wrap-around.** Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are decided from `fifo_level`.
- **Full FIFO with pop in the same cycle.** A simultaneous push is accepted; the level is unchanged.
- **Full FIFO without a pop.** The push is dropped and `overflow` rises at that edge.
- **Reset mid-sample** (in SEND_HI or SEND_LO): outputs clear asynchronously and the partial sample is discarded. After reset release, the first byte emitted is always a HI byte.
- **`out_ready` while `out_valid`=0.** Ignored.

## Structure
- **Shared package `fir_pkg`:**
  - default `Y_N_SIZE`
  - packed word width 14
  - FSM state encoding localparams (IDLE=2'b00, SEND_HI=2'b01, SEND_LO=2'b10)
  - HI/LO marker bit constants
- **Sub-module `fir_sync_fifo`:** parameterised width/depth, push/pop/level, no internal drop logic. The drop decision and `overflow` live in the packer.
- **Top of the packer:** FSM, output word register, byte mux.

## Test plan
- Reset, then push `y_n`=−3 with `out_ready`=1 → bytes 0xFF then 0x7D on consecutive cycles; `fifo_level` returns to 0.
- Push 300, 1023, −1024 on consecutive cycles, `out_ready`=1 → 0x82, 0x2C, 0x87, 0x7F, 0xF8, 0x00 with no gap between bytes; `overflow`=0.
- Hold `out_ready`=0 and push 6 samples (DEPTH=4) → the first popped sample is held as a stable HI byte. The FIFO accepts samples 2–5 (`fifo_level`=4), sample 6 is dropped and `overflow`=1 from that edge. Releasing `out_ready` drains samples 1–5 in order.
- FIFO full and a pop in the same cycle as a push → the push is accepted, `fifo_level` stays 4, `overflow` stays 0.
- Assert `reset` while in SEND_LO → `out_valid`, `out_byte`, `fifo_level` are 0 immediately, without a clock edge. The next pushed sample 300 yields 0x82 first.
- Toggle `out_ready` randomly over 50 samples → every HI byte (bit 7=1) is followed by its LO byte (bit 7=0), and the reassembled values match the pushed values.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage.
// Word format, FSM encoding and framing markers.
package fir_pkg;

  localparam int Y_N_SIZE_DEF = 11;
  localparam int WORD_W = 14;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND_HI = 2'b01;
  localparam logic [1:0] ST_SEND_LO = 2'b10;

  localparam logic HI_MARK = 1'b1;
  localparam logic LO_MARK = 1'b0;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND_HI = ST_SEND_HI,
    SEND_LO = ST_SEND_LO
  } state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module fir_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10: level <= level + LW'(1);
        2'b01: level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fir_out_packer.sv
// Buffers filter results and emits each as a HI/LO
// byte pair; bit 7 flags the HI byte for resync.
module fir_out_packer
  import fir_pkg::*;
#(
  parameter int Y_N_SIZE = Y_N_SIZE_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Y_N_SIZE-1:0] y_n,
  input  logic                y_valid,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [LW-1:0]       fifo_level
);

  state_t state_q;
  state_t state_d;
  logic [WORD_W-1:0] word_q;
  logic [Y_N_SIZE-1:0] fifo_dout;
  logic pop;
  logic push_ok;
  logic full;
  logic avail;

  assign full = (fifo_level == LW'(FIFO_DEPTH));
  assign avail = (fifo_level != '0);
  // a pop frees a slot in the same edge, so full+pop still accepts
  assign push_ok = y_valid && (!full || pop);

  fir_sync_fifo #(
    .WIDTH(Y_N_SIZE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_ok),
    .pop(pop),
    .wdata(y_n),
    .rdata(fifo_dout),
    .level(fifo_level)
  );

  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    out_valid = 1'b0;
    out_byte = '0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          pop = 1'b1;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_byte = {HI_MARK, word_q[13:7]};
        if (out_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_byte = {LO_MARK, word_q[6:0]};
        if (out_ready) begin
          if (avail) begin
            pop = 1'b1;
            state_d = SEND_HI;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) word_q <= WORD_W'($signed(fifo_dout));
      if (y_valid && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_packer.sv
// Directed bench for fir_out_packer.
// Hand-computed byte sequences plus a reassembly run.
module tb_fir_out_packer;

  logic clk;
  logic reset;
  logic signed [10:0] y_n;
  logic y_valid;
  logic [7:0] out_byte;
  logic out_valid;
  logic out_ready;
  logic overflow;
  logic [2:0] fifo_level;

  int n_chk;
  int n_fail;

  fir_out_packer #(
    .Y_N_SIZE(11),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .y_n(y_n),
    .y_valid(y_valid),
    .out_byte(out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    y_valid = 1'b0;
  endtask

  task automatic push(input int v);
    y_n = 11'(v);
    y_valid = 1'b1;
  endtask

  task automatic do_reset();
    y_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic expect_seq(input string tag, input int b[$]);
    foreach (b[i]) begin
      chk({tag, "_v"}, out_valid, 1);
      chk({tag, "_b"}, out_byte, b[i]);
      tick();
    end
    chk({tag, "_end"}, out_valid, 0);
  endtask

  initial begin
    int exp_q[$];
    int got;
    int sent;
    bit hi_seen;
    logic [7:0] hi_b;
    logic signed [13:0] rw;
    int r;
    bit xfer;
    logic [7:0] xb;
    int v;

    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    y_n = '0;
    y_valid = 1'b0;
    out_ready = 1'b0;

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_lvl", fifo_level, 0);

    // single sample -3
    out_ready = 1'b1;
    push(-3);
    tick();
    chk("m3_lvl1", fifo_level, 1);
    chk("m3_idle", out_valid, 0);
    tick();
    chk("m3_hi_v", out_valid, 1);
    chk("m3_hi", out_byte, 'hFF);
    chk("m3_lvl0", fifo_level, 0);
    tick();
    chk("m3_lo", out_byte, 'h7D);
    tick();
    chk("m3_done", out_valid, 0);
    chk("m3_lvl", fifo_level, 0);

    // back-to-back 300, 1023, -1024
    push(300);
    tick();
    chk("b2b_lat", out_valid, 0);
    push(1023);
    tick();
    chk("b2b_0", out_byte, 'h82);
    push(-1024);
    tick();
    expect_seq("b2b", '{'h2C, 'h87, 'h7F, 'hF8, 'h00});
    chk("b2b_ovf", overflow, 0);

    // stall and overflow
    do_reset();
    push(10);
    tick();
    push(20);
    tick();
    chk("st_hi_v", out_valid, 1);
    chk("st_hi", out_byte, 'h80);
    chk("st_lvl1", fifo_level, 1);
    push(30);
    tick();
    push(40);
    tick();
    push(50);
    tick();
    chk("st_lvl4", fifo_level, 4);
    chk("st_ovf0", overflow, 0);
    push(60);
    tick();
    chk("st_ovf1", overflow, 1);
    chk("st_lvl4b", fifo_level, 4);
    tick();
    chk("st_hold", out_byte, 'h80);
    chk("st_hold_v", out_valid, 1);
    out_ready = 1'b1;
    expect_seq("st", '{'h80, 'h0A, 'h80, 'h14, 'h80, 'h1E,
                       'h80, 'h28, 'h80, 'h32});
    chk("st_ovf_sticky", overflow, 1);

    // full FIFO with simultaneous pop and push
    do_reset();
    push(10);
    tick();
    push(20);
    tick();
    push(30);
    tick();
    push(40);
    tick();
    push(50);
    tick();
    chk("fp_lvl4", fifo_level, 4);
    out_ready = 1'b1;
    tick();
    chk("fp_lo", out_byte, 'h0A);
    chk("fp_lvl4b", fifo_level, 4);
    push(70);
    tick();
    chk("fp_lvl_keep", fifo_level, 4);
    chk("fp_ovf", overflow, 0);
    expect_seq("fp", '{'h80, 'h14, 'h80, 'h1E, 'h80, 'h28,
                       'h80, 'h32, 'h80, 'h46});

    // asynchronous reset in SEND_LO
    do_reset();
    out_ready = 1'b1;
    push(300);
    tick();
    push(1023);
    tick();
    tick();
    chk("ar_lo", out_byte, 'h2C);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_byte", out_byte, 0);
    chk("ar_lvl", fifo_level, 0);
    tick();
    #2;
    reset = 1'b0;
    tick();
    push(300);
    tick();
    chk("ar_idle", out_valid, 0);
    tick();
    chk("ar_first_v", out_valid, 1);
    chk("ar_first", out_byte, 'h82);
    out_ready = 1'b0;
    do_reset();

    // random out_ready, 50 samples reassembled
    got = 0;
    sent = 0;
    hi_seen = 1'b0;
    hi_b = '0;
    for (int cyc = 0; cyc < 3000 && got < 50; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 50 && fifo_level < 3'd4) begin
        v = int'($urandom_range(0, 2047)) - 1024;
        exp_q.push_back(v);
        push(v);
        sent++;
      end
      xfer = out_valid && out_ready;
      xb = out_byte;
      tick();
      if (xfer) begin
        if (xb[7]) begin
          chk("rt_frame_hi", int'(hi_seen), 0);
          hi_seen = 1'b1;
          hi_b = xb;
        end else begin
          chk("rt_frame_lo", int'(hi_seen), 1);
          hi_seen = 1'b0;
          rw = {hi_b[6:0], xb[6:0]};
          r = rw;
          if (exp_q.size() > 0) chk("rt_val", r, exp_q.pop_front());
          else chk("rt_extra", 1, 0);
          got++;
        end
      end
    end
    chk("rt_count", got, 50);
    chk("rt_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
